// File: rtl/clk_step_pkg.sv
// Mode encodings and FSM state type shared by the clock step controller.
package clk_step_pkg;

    localparam logic [1:0] MODE_STOP      = 2'b00;
    localparam logic [1:0] MODE_RUN       = 2'b01;
    localparam logic [1:0] MODE_STEP_HOLD = 2'b10;
    localparam logic [1:0] MODE_HALTED    = 2'b11;

    typedef enum logic [1:0] {
        ST_STOP      = MODE_STOP,
        ST_RUN       = MODE_RUN,
        ST_STEP_HOLD = MODE_STEP_HOLD,
        ST_HALTED    = MODE_HALTED
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw board input.
// Output follows a settled pin 2 + DEBOUNCE cycles later; no flow control.
module btn_debounce #(
    parameter int DEBOUNCE = 1000000,
    parameter int DB_W     = 20
) (
    input  logic clk_in,
    input  logic rst,
    input  logic raw,
    output logic db
);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any cycle of agreement restarts the stability window.
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE - 1)) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/stop/single-step clock-enable sequencer with core halt override.
// All outputs registered; tick one cycle after the deciding condition; no flow control.
module clk_step_ctrl #(
    parameter int PERIOD   = 200000000,
    parameter int CNT_W    = 28,
    parameter int DEBOUNCE = 1000000,
    parameter int DB_W     = 20
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       run_sw,
    input  logic       step_btn,
    input  logic       halt,
    output logic       tick,
    output logic       clk_out,
    output logic [1:0] mode,
    output logic [7:0] tick_cnt
);

    import clk_step_pkg::*;

    logic             run_db;
    logic             step_db;
    logic             step_prev;
    logic             step_rise;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tick_nxt;

    btn_debounce #(.DEBOUNCE(DEBOUNCE), .DB_W(DB_W)) u_run_db (
        .clk_in (clk_in),
        .rst    (rst),
        .raw    (run_sw),
        .db     (run_db)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE), .DB_W(DB_W)) u_step_db (
        .clk_in (clk_in),
        .rst    (rst),
        .raw    (step_btn),
        .db     (step_db)
    );

    assign step_rise = step_db & ~step_prev;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tick_nxt  = 1'b0;
        // Halt outranks everything, including a tick due this cycle.
        if (halt) begin
            state_nxt = ST_HALTED;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                ST_STOP: begin
                    if (run_db) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else if (step_rise) begin
                        state_nxt = ST_STEP_HOLD;
                        tick_nxt  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run_db) begin
                        state_nxt = ST_STOP;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(PERIOD - 1)) begin
                        cnt_nxt  = '0;
                        tick_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_STEP_HOLD: begin
                    if (!step_db) state_nxt = ST_STOP;
                end
                ST_HALTED: begin
                    if (!run_db) state_nxt = ST_STOP;
                end
                default: state_nxt = ST_STOP;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= ST_STOP;
            cnt       <= '0;
            tick      <= 1'b0;
            clk_out   <= 1'b0;
            tick_cnt  <= '0;
            step_prev <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tick      <= tick_nxt;
            step_prev <= step_db;
            if (tick_nxt) begin
                clk_out  <= ~clk_out;
                tick_cnt <= tick_cnt + 8'd1;
            end
        end
    end

    assign mode = state;

endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

Run/stop/single-step clock controller for the FPGA demo boards. It sequences the processor's slow clock from board switches and buttons: free-running at a divided rate, stopped, or advanced one tick per button press. It also honours a halt request from the processor core. It produces a one-cycle clock-enable `tick` plus a square-wave `clk_out` for LEDs, and sits between board I/O and the processor's clock enable.

## Interface
- `PERIOD`, 200000000, clk_in cycles between ticks in RUN; must be ≥ 2.
- `CNT_W`, 28, period counter width; must satisfy 2^CNT_W > PERIOD.
- `DEBOUNCE`, 1000000, stable cycles required before a debounced input changes; must be ≥ 2.
- `DB_W`, 20, debounce counter width; must satisfy 2^DB_W > DEBOUNCE.
- `clk_in`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `run_sw`  in  1  raw slide switch; asynchronous; 1 = run.
- `step_btn`  in  1  raw push button; asynchronous; 1 = pressed.
- `halt`  in  1  synchronous halt request from the core, sampled every cycle.
- `tick`  out  1  registered one-cycle clock-enable pulse.
- `clk_out`  out  1  registered; toggles on every tick.
- `mode`  out  2  registered state: 00 STOP, 01 RUN, 10 STEP_HOLD, 11 HALTED.
- `tick_cnt`  out  8  registered tick counter; wraps from 255 to 0.

## Operation
- **Synchronisation:** each of `run_sw` and `step_btn` passes through a 2-flop synchroniser and then a debouncer.
  - Debouncer counter clears whenever the synced value equals the debounced value; otherwise it increments.
  - When the counter reaches DEBOUNCE-1 and the values still differ, the debounced value takes the synced value and the counter clears.
- **Edge detection:** `step_rise` = debounced step AND NOT (its value one cycle earlier).
- **STOP:**
  - If run_db = 1: go to RUN and clear the period counter.
  - Else if step_rise: go to STEP_HOLD and register `tick` = 1.
- **RUN:**
  - The period counter increments each cycle; at PERIOD-1 it reloads 0 and registers `tick` = 1.
  - If run_db = 0: go to STOP, clear the counter, and emit no tick that cycle.
  - Step presses are ignored.
- **STEP_HOLD:** `tick` is 0; return to STOP when step_db = 0. Holding the button produces exactly one tick.
- **HALTED:**
  - Entered from any state when `halt` = 1. This takes priority over every other transition, and any tick that would register in that cycle is suppressed.
  - Exit to STOP when run_db = 0 and `halt` = 0.
- **Simultaneous events:** in STOP, run_db = 1 together with step_rise goes to RUN and the step is dropped.
- **Tick side effects:** every tick toggles `clk_out` and increments `tick_cnt` (modulo 256) in the same cycle as `tick`.
- **Reset:** `rst` = 1 forces all of the following, from any state, mid-period included:
  - mode = STOP;
  - `tick`, `clk_out`, `tick_cnt`, period counter and debounce counters = 0;
  - debounced values, edge history and synchroniser flops = 0.

## Timing
- Pin → debounced value: 2 + DEBOUNCE cycles after the pin settles.
- Debounced step edge → `tick` high: 1 cycle; `mode` shows STEP_HOLD in the same cycle.
- RUN entry: `mode` = 01 one cycle after run_db rises; the first `tick` follows PERIOD cycles after that.
- Tick spacing in RUN is exactly PERIOD cycles, so `clk_out` period = 2·PERIOD cycles.
- `halt` → `mode` = 11 one cycle later.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `clk_step_pkg`:
  - mode encoding constants MODE_STOP / MODE_RUN / MODE_STEP_HOLD / MODE_HALTED;
  - the state typedef.
- Sub-module `btn_debounce` (params DEBOUNCE, DB_W): contains the synchroniser and debouncer, with ports clk_in, rst, raw, db. It is instantiated twice, for run and for step.
- The top level holds the FSM, period counter, clk_out toggle and tick_cnt.

## Test plan
Bench parameters: PERIOD = 5, DEBOUNCE = 4.

1. **Reset:** rst for 3 cycles with run_sw = 1 → all outputs 0, mode = 00 during reset; mode = 01 seven cycles after rst falls.
2. **RUN spacing:** run_sw = 1 held → ticks exactly 5 cycles apart; clk_out toggles on each tick; tick_cnt reaches 3 after the 3rd tick.
3. **Single step:** in STOP, step_btn held 20 cycles → exactly one tick, 7 cycles after the press; mode 00→10→00 after release.
4. **Bounce:** step_btn glitches 1,0,1 on single cycles, then holds → no tick until 4 stable synced cycles have elapsed.
5. **Halt priority:** halt asserted on the cycle the counter hits 4 → no tick, mode = 11 next cycle; mode stays 11 until run_sw = 0 is debounced, then returns to 00.
6. **Tick wrap and mid-period reset:** 256 ticks → tick_cnt = 0; rst at counter = 2 in RUN → next tick occurs a full 5 cycles after RUN is re-entered.
